// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
// Holds the sweep FSM state type, default geometry constants and the
// helper that pulls one port's field out of a packed multi-port vector.
// Optional feature macro used by the design: REGFILE_BYPASS_EN.

package regfile_pkg;

    // Sweep controller states: IDLE accepts writes, CLEAR zeroes the array.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    // Default geometry of the MIPS register file.
    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_RD = 2;

    // Widest packed vector and widest single field the slice helper handles.
    localparam int PACK_MAX_W  = 256;
    localparam int FIELD_MAX_W = 64;

    // Extract field port_idx (each field_w bits wide) from a packed vector.
    // Callers zero-extend their vector to PACK_MAX_W and truncate the result
    // back to their own field width.
    function automatic logic [FIELD_MAX_W-1:0] port_slice(
        input logic [PACK_MAX_W-1:0] packed_vec,
        input int unsigned           port_idx,
        input int unsigned           field_w
    );
        logic [PACK_MAX_W-1:0]  shifted_s;
        logic [FIELD_MAX_W-1:0] mask_s;
        shifted_s = packed_vec >> (port_idx * field_w);
        if (field_w >= 32'd64) begin
            mask_s = {FIELD_MAX_W{1'b1}};
        end else begin
            mask_s = (64'd1 << field_w) - 64'd1;
        end
        return shifted_s[FIELD_MAX_W-1:0] & mask_s;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequential clear sweep controller for the register file.
// After reset (or a clear request from IDLE) it walks ptr over every entry,
// issuing one zero-write per cycle, then returns to IDLE. It also reports
// writes that arrive while the sweep is running.

module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              write_req,
    output logic              ready,
    output logic              write_dropped,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    rf_state_e         state_r;
    rf_state_e         state_next_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_next_s;
    logic              ready_r;
    logic              write_dropped_r;
    logic              dropped_next_s;
    logic              sweep_we_s;

    // Next-state, next-pointer and sweep write strobe.
    always_comb begin
        state_next_s   = state_r;
        ptr_next_s     = ptr_r;
        sweep_we_s     = 1'b0;
        dropped_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_next_s = CLEAR;
                    ptr_next_s   = PTR_ZERO;
                end else begin
                    state_next_s = IDLE;
                    ptr_next_s   = ptr_r;
                end
            end
            CLEAR: begin
                // clear_req is deliberately ignored here: a sweep never restarts.
                sweep_we_s = ~reset;
                if (ptr_r == PTR_LAST) begin
                    state_next_s = IDLE;
                    ptr_next_s   = PTR_ZERO;
                end else begin
                    state_next_s = CLEAR;
                    ptr_next_s   = ptr_r + PTR_ONE;
                end
                if (write_req) begin
                    dropped_next_s = 1'b1;
                end else begin
                    dropped_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s = CLEAR;
                ptr_next_s   = PTR_ZERO;
            end
        endcase
    end

    // State, pointer and registered status outputs; reset restarts the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= CLEAR;
            ptr_r           <= PTR_ZERO;
            ready_r         <= 1'b0;
            write_dropped_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            ptr_r           <= ptr_next_s;
            ready_r         <= (state_next_s == IDLE);
            write_dropped_r <= dropped_next_s;
        end
    end

    assign ready         = ready_r;
    assign write_dropped = write_dropped_r;
    assign sweep_we      = sweep_we_s;
    assign sweep_addr    = ptr_r;

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file with NUM_RD combinational
// read ports, one write port, an optional hardwired-zero entry 0 and a
// sequential clear sweep (see regfile_clear_fsm).
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read of the
// address being written in the same cycle returns the new data (write-first);
// otherwise the stored value is returned (read-first).
// DATA_W must not exceed 64 and NUM_RD*ADDR_W must not exceed 256.

module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        write_register,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_register,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic                     ready,
    output logic                     write_dropped
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic              sweep_we_s;
    logic [ADDR_W-1:0] sweep_addr_s;
    logic              user_we_s;
    logic              ready_s;

    // Storage has no reset so it can map onto RAM; the sweep clears it.
    logic [DATA_W-1:0] mem_r [DEPTH];

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clock         (clock),
        .reset         (reset),
        .clear_req     (clear_req),
        .write_req     (RegWrite),
        .ready         (ready_s),
        .write_dropped (write_dropped),
        .sweep_we      (sweep_we_s),
        .sweep_addr    (sweep_addr_s)
    );

    assign ready = ready_s;

    // Qualify the user write: only in IDLE, never to a hardwired-zero entry 0.
    always_comb begin
        user_we_s = 1'b0;
        if ((ZERO_REG != 0) && (write_register == ADDR_ZERO)) begin
            user_we_s = 1'b0;
        end else if (ready_s && RegWrite && !reset) begin
            user_we_s = 1'b1;
        end else begin
            user_we_s = 1'b0;
        end
    end

    // Array write port: sweep zero-writes and user writes are never concurrent.
    always_ff @(posedge clock) begin
        if (sweep_we_s) begin
            mem_r[sweep_addr_s] <= DATA_ZERO;
        end else if (user_we_s) begin
            mem_r[write_register] <= write_data;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr_s;
        logic [DATA_W-1:0] rd_data_s;

        assign rd_addr_s = ADDR_W'(port_slice(PACK_MAX_W'(read_register),
                                              gi, ADDR_W));

        // Combinational read: masked while sweeping and for entry 0.
        always_comb begin
            rd_data_s = DATA_ZERO;
            if (!ready_s) begin
                rd_data_s = DATA_ZERO;
            end else if ((ZERO_REG != 0) && (rd_addr_s == ADDR_ZERO)) begin
                rd_data_s = DATA_ZERO;
`ifdef REGFILE_BYPASS_EN
            end else if (user_we_s && (rd_addr_s == write_register)) begin
                rd_data_s = write_data;
`endif
            end else begin
                rd_data_s = mem_r[rd_addr_s];
            end
        end

        assign read_data[gi*DATA_W +: DATA_W] = rd_data_s;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed scoreboard bench for regfile_multiport
// (NUM_RD=3, 32x32, ZERO_REG=1). Stimulus pushes expectations tagged with the
// cycle they apply to; a monitor on the falling edge pops and compares them.

module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    localparam int K_P0 = 0;
    localparam int K_P1 = 1;
    localparam int K_P2 = 2;
    localparam int K_RDY = 3;
    localparam int K_WD = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              clear_req;
    logic              RegWrite;
    logic [AW-1:0]     write_register;
    logic [DW-1:0]     write_data;
    logic [NR*AW-1:0]  read_register;
    logic [NR*DW-1:0]  read_data;
    logic              ready;
    logic              write_dropped;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    regfile_multiport #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear_req      (clear_req),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .read_register  (read_register),
        .read_data      (read_data),
        .ready          (ready),
        .write_dropped  (write_dropped)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    function automatic string kind_name(input int k);
        case (k)
            K_P0:    return "read_data_p0";
            K_P1:    return "read_data_p1";
            K_P2:    return "read_data_p2";
            K_RDY:   return "ready";
            K_WD:    return "write_dropped";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_val(input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_reads(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c);
        expect_val(K_P0, a);
        expect_val(K_P1, b);
        expect_val(K_P2, c);
    endtask

    task automatic set_reads(input int a, input int b, input int c);
        read_register = {AW'(c), AW'(b), AW'(a)};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                if (e.kind == K_RDY) begin
                    act = {31'd0, ready};
                end else if (e.kind == K_WD) begin
                    act = {31'd0, write_dropped};
                end else begin
                    act = read_data[e.kind*DW +: DW];
                end
                checks = checks + 1;
                if (act !== e.val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got=%h expected=%h",
                             kind_name(e.kind), e.cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        clear_req      = 1'b0;
        RegWrite       = 1'b0;
        write_register = '0;
        write_data     = '0;
        set_reads(0, 1, 2);

        // Reset held for two edges.
        step();
        step();
        expect_val(K_RDY, 32'd0);
        expect_val(K_WD, 32'd0);
        expect_reads(32'd0, 32'd0, 32'd0);
        reset = 1'b0;

        // Power-on sweep: ready low for cycles 0..31, high at cycle 32.
        for (int k = 0; k < 32; k++) begin
            set_reads(k, 31 - k, 0);
            expect_val(K_RDY, 32'd0);
            expect_reads(32'd0, 32'd0, 32'd0);
            step();
        end
        set_reads(5, 31, 0);
        expect_val(K_RDY, 32'd1);
        expect_reads(32'd0, 32'd0, 32'd0);

        // Write r5 and r31; same-cycle reads depend on bypass.
        RegWrite = 1'b1; write_register = 5'd5; write_data = 32'hDEADBEEF;
        expect_reads(BYP ? 32'hDEADBEEF : 32'd0, 32'd0, 32'd0);
        step();
        write_register = 5'd31; write_data = 32'h12345678;
        expect_reads(32'hDEADBEEF, BYP ? 32'h12345678 : 32'd0, 32'd0);
        step();
        RegWrite = 1'b0;
        expect_reads(32'hDEADBEEF, 32'h12345678, 32'd0);
        expect_val(K_WD, 32'd0);
        step();

        // Same-cycle read of the written address r7.
        set_reads(5, 31, 7);
        RegWrite = 1'b1; write_register = 5'd7; write_data = 32'hA5A5A5A5;
        expect_reads(32'hDEADBEEF, 32'h12345678, BYP ? 32'hA5A5A5A5 : 32'd0);
        step();
        RegWrite = 1'b0;
        expect_reads(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5);
        step();

        // r0 is hardwired to zero; a write to it is silently discarded.
        set_reads(0, 7, 0);
        RegWrite = 1'b1; write_register = 5'd0; write_data = 32'hFFFFFFFF;
        expect_reads(32'd0, 32'hA5A5A5A5, 32'd0);
        step();
        RegWrite = 1'b0;
        expect_reads(32'd0, 32'hA5A5A5A5, 32'd0);
        expect_val(K_WD, 32'd0);
        step();

        // Fill r1..r31 with distinct nonzero values.
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1'b1; write_register = AW'(i);
            write_data = 32'hC0DE0000 | 32'(i);
            step();
        end
        RegWrite = 1'b0;
        set_reads(1, 3, 31);
        expect_reads(32'hC0DE0001, 32'hC0DE0003, 32'hC0DE001F);
        expect_val(K_RDY, 32'd1);

        // Clear request: ready low for 32 cycles, one dropped write at k=10,
        // a second clear_req mid-sweep must not restart it.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        set_reads(3, 5, 31);
        for (int k = 0; k < 32; k++) begin
            expect_val(K_RDY, 32'd0);
            expect_reads(32'd0, 32'd0, 32'd0);
            expect_val(K_WD, (k == 11) ? 32'd1 : 32'd0);
            RegWrite  = (k == 10);
            write_register = 5'd3; write_data = 32'h33333333;
            clear_req = (k == 20);
            step();
        end
        RegWrite  = 1'b0;
        clear_req = 1'b0;
        expect_val(K_RDY, 32'd1);
        expect_val(K_WD, 32'd0);
        for (int g = 0; g < 11; g++) begin
            set_reads(3 * g, 3 * g + 1, (3 * g + 2) % 32);
            expect_reads(32'd0, 32'd0, 32'd0);
            step();
        end

        // Reset mid-sweep at ptr=10 restarts the sweep from 0.
        RegWrite = 1'b1; write_register = 5'd9; write_data = 32'h99999999;
        step();
        RegWrite = 1'b0;
        set_reads(9, 4, 0);
        expect_reads(32'h99999999, 32'hC0DE0004 & 32'd0, 32'd0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_val(K_RDY, 32'd0);
            step();
        end
        reset = 1'b1;
        RegWrite = 1'b1; write_register = 5'd4; write_data = 32'h44444444;
        step();
        reset = 1'b0;
        RegWrite = 1'b0;
        expect_val(K_WD, 32'd0);
        for (int k = 0; k < 32; k++) begin
            expect_val(K_RDY, 32'd0);
            step();
        end
        expect_val(K_RDY, 32'd1);
        expect_reads(32'd0, 32'd0, 32'd0);
        step();
        step();

        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
